// File: rtl/elevator_pkg.sv
// Shared types and default constants for the elevator controller and its tick generator.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StMoving   = 2'd1,
    StDoorOpen = 2'd2
  } state_e;

  typedef enum logic {
    DirDown = 1'b0,
    DirUp   = 1'b1
  } dir_e;

  // Result of a SCAN decision: whether to move at all, and which way.
  typedef struct packed {
    logic go;
    dir_e dir;
  } scan_t;

  localparam int unsigned DefaultNumFloors   = 4;
  localparam int unsigned DefaultClkDiv      = 520833;
  localparam int unsigned DefaultTravelTicks = 3;
  localparam int unsigned DefaultDoorTicks   = 5;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-clk enable pulse every CLK_DIV clocks.
module tick_gen
  import elevator_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefaultClkDiv
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_tick;

  // First pulse is visible CLK_DIV clocks after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CntMax) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CntW'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: latches floor calls, moves the cab one floor per TRAVEL_TICKS
// ticks and holds the door for DOOR_TICKS ticks; all outputs are registered.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = DefaultNumFloors,
  parameter int unsigned CLK_DIV      = DefaultClkDiv,
  parameter int unsigned TRAVEL_TICKS = DefaultTravelTicks,
  parameter int unsigned DOOR_TICKS   = DefaultDoorTicks,
  localparam int unsigned FloorW      = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FloorW-1:0]     floor,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TravW = $clog2(TRAVEL_TICKS + 1);
  localparam int unsigned DoorW = $clog2(DOOR_TICKS + 1);
  localparam logic [FloorW-1:0] TopFloor = FloorW'(NUM_FLOORS - 1);
  localparam logic [TravW-1:0]  TravLoad = TravW'(TRAVEL_TICKS);
  localparam logic [DoorW-1:0]  DoorLoad = DoorW'(DOOR_TICKS);

  state_e                r_state, w_state_d;
  dir_e                  r_dir, w_dir_d;
  logic [FloorW-1:0]     r_floor, w_floor_d, w_step_floor;
  logic [NUM_FLOORS-1:0] r_pending, w_pending_d, w_req_eff;
  logic [TravW-1:0]      r_trav_cnt, w_trav_d;
  logic [DoorW-1:0]      r_door_cnt, w_door_d;
  logic                  r_motor_up, r_motor_down, r_door_open;
  logic                  w_tick;
  scan_t                 w_scan_here, w_scan_step;

  tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FloorW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) if (p[i] && (i > int'(f))) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FloorW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) if (p[i] && (i < int'(f))) r = 1'b1;
    return r;
  endfunction

  // Keep heading while work lies ahead, otherwise turn around if work lies behind.
  function automatic scan_t scan_dir(input logic [NUM_FLOORS-1:0] p, input logic [FloorW-1:0] f,
                                     input dir_e d);
    scan_t s;
    logic  up_ok, dn_ok;
    up_ok = any_above(p, f);
    dn_ok = any_below(p, f);
    s.go  = up_ok | dn_ok;
    s.dir = d;
    if (d == DirUp && !up_ok && dn_ok) s.dir = DirDown;
    if (d == DirDown && !dn_ok && up_ok) s.dir = DirUp;
    return s;
  endfunction

  always_comb begin
    w_step_floor = r_floor;
    if (r_dir == DirUp && r_floor != TopFloor) w_step_floor = r_floor + FloorW'(1);
    if (r_dir == DirDown && r_floor != '0) w_step_floor = r_floor - FloorW'(1);
  end

  assign w_req_eff   = r_pending | call_req;
  assign w_scan_here = scan_dir(r_pending, r_floor, r_dir);
  assign w_scan_step = scan_dir(r_pending, w_step_floor, r_dir);

  always_comb begin
    w_state_d = r_state;
    w_dir_d   = r_dir;
    w_floor_d = r_floor;
    w_trav_d  = r_trav_cnt;
    w_door_d  = r_door_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_req_eff[r_floor]) begin
          w_state_d = StDoorOpen;
          w_door_d  = DoorLoad;
        end else if (any_above(w_req_eff, r_floor)) begin
          w_state_d = StMoving;
          w_dir_d   = DirUp;
          w_trav_d  = TravLoad;
        end else if (any_below(w_req_eff, r_floor)) begin
          w_state_d = StMoving;
          w_dir_d   = DirDown;
          w_trav_d  = TravLoad;
        end
      end
      StMoving: begin
        if (w_tick) begin
          if (r_trav_cnt <= TravW'(1)) begin
            w_floor_d = w_step_floor;
            w_trav_d  = TravLoad;
            // Only calls already latched before this tick can stop the cab here.
            if (r_pending[w_step_floor]) begin
              w_state_d = StDoorOpen;
              w_door_d  = DoorLoad;
            end else if (w_scan_step.go) begin
              w_dir_d = w_scan_step.dir;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_trav_d = r_trav_cnt - TravW'(1);
          end
        end
      end
      StDoorOpen: begin
        if (call_req[r_floor]) begin
          w_door_d = DoorLoad;
        end else if (w_tick) begin
          if (r_door_cnt <= DoorW'(1)) begin
            w_door_d = '0;
            if (w_scan_here.go) begin
              w_state_d = StMoving;
              w_dir_d   = w_scan_here.dir;
              w_trav_d  = TravLoad;
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_door_d = r_door_cnt - DoorW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Serving a floor clears its bit and wins over a same-cycle call for it.
  always_comb begin
    w_pending_d = r_pending | call_req;
    if (w_state_d == StDoorOpen) w_pending_d[w_floor_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_dir        <= DirUp;
      r_floor      <= '0;
      r_pending    <= '0;
      r_trav_cnt   <= '0;
      r_door_cnt   <= '0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
      r_door_open  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_dir        <= w_dir_d;
      r_floor      <= w_floor_d;
      r_pending    <= w_pending_d;
      r_trav_cnt   <= w_trav_d;
      r_door_cnt   <= w_door_d;
      r_motor_up   <= (w_state_d == StMoving) && (w_dir_d == DirUp);
      r_motor_down <= (w_state_d == StMoving) && (w_dir_d == DirDown);
      r_door_open  <= (w_state_d == StDoorOpen);
    end
  end

  assign floor      = r_floor;
  assign motor_up   = r_motor_up;
  assign motor_down = r_motor_down;
  assign door_open  = r_door_open;
  assign pending    = r_pending;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: expected output changes and snapshots are queued by the
// stimulus process and checked by an independent monitor against the cycle count since reset.
module tb_elevator_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] call_req = 4'b0;
  logic [1:0] floor;
  logic       motor_up, motor_down, door_open;
  logic [3:0] pending;

  elevator_ctrl #(
    .NUM_FLOORS  (4),
    .CLK_DIV     (4),
    .TRAVEL_TICKS(3),
    .DOOR_TICKS  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .call_req  (call_req),
    .floor     (floor),
    .motor_up  (motor_up),
    .motor_down(motor_down),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release; ticks fall on edges 5, 9, 13, ...
  int n = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) n = 0;
    else n = n + 1;
  end

  typedef struct {
    int         at;
    logic [1:0] fl;
    logic       up;
    logic       dn;
    logic       dr;
    logic [3:0] pend;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  snap_q[$];
  int   tests = 0;
  int   fails = 0;
  logic done = 1'b0;

  task automatic push(input bit is_snap, input int at, input int fl, input bit up, input bit dn,
                      input bit dr, input logic [3:0] pend);
    ev_t e;
    e.at = at; e.fl = 2'(fl); e.up = up; e.dn = dn; e.dr = dr; e.pend = pend;
    if (is_snap) snap_q.push_back(e);
    else exp_q.push_back(e);
  endtask

  task automatic wait_n(input int k);
    while (n < k) @(negedge clk);
  endtask

  // Asserts reset mid-cycle, away from any clock edge, and expects outputs cleared at once.
  task automatic do_reset();
    push(1, 0, 0, 0, 0, 0, 4'b0000);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [4:0] obs;
  logic [4:0] prev_obs = 5'b0;
  logic       prev_rst = 1'b1;
  assign obs = {floor, motor_up, motor_down, door_open};

  always @(negedge clk) begin : mon
    ev_t e;
    if (prev_rst && !rst) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL missed_events: %0d still queued at reset, want 0", exp_q.size());
        exp_q.delete();
      end
    end
    prev_rst = rst;
    if (!rst) begin
      prev_obs = 5'b0;
    end else if (obs !== prev_obs) begin
      prev_obs = obs;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: n=%0d fl=%0d up=%b dn=%b door=%b pend=%b", n, floor,
                 motor_up, motor_down, door_open, pending);
      end else begin
        e = exp_q.pop_front();
        if (e.at != n || {floor, motor_up, motor_down, door_open, pending} !==
            {e.fl, e.up, e.dn, e.dr, e.pend}) begin
          fails++;
          $display("FAIL event: got n=%0d fl=%0d up=%b dn=%b door=%b pend=%b, want n=%0d fl=%0d up=%b dn=%b door=%b pend=%b",
                   n, floor, motor_up, motor_down, door_open, pending,
                   e.at, e.fl, e.up, e.dn, e.dr, e.pend);
        end
      end
    end
    if (snap_q.size() != 0 && snap_q[0].at == n) begin
      e = snap_q.pop_front();
      tests++;
      if ({floor, motor_up, motor_down, door_open, pending} !== {e.fl, e.up, e.dn, e.dr, e.pend})
      begin
        fails++;
        $display("FAIL snapshot@%0d rst=%b: got fl=%0d up=%b dn=%b door=%b pend=%b, want fl=%0d up=%b dn=%b door=%b pend=%b",
                 e.at, rst, floor, motor_up, motor_down, door_open, pending,
                 e.fl, e.up, e.dn, e.dr, e.pend);
      end
    end
    if (done) begin
      tests += 2;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL final_events: %0d still queued, want 0", exp_q.size());
      end
      if (snap_q.size() != 0) begin
        fails++;
        $display("FAIL final_snapshots: %0d still queued, want 0", snap_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset and idle check.
    push(1, 0, 0, 0, 0, 0, 4'b0000);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push(1, 100, 0, 0, 0, 0, 4'b0000);

    // Same-floor call in idle: door opens next clk, closes 20 clk later.
    push(0, 101, 0, 0, 0, 1, 4'b0000);
    push(0, 121, 0, 0, 0, 0, 4'b0000);
    wait_n(100); call_req = 4'b0001;
    wait_n(101); call_req = 4'b0000;

    // Travel 0 -> 3: one floor per 12 clk, door at 3, then idle.
    push(0, 125, 0, 1, 0, 0, 4'b1000);
    push(0, 137, 1, 1, 0, 0, 4'b1000);
    push(0, 149, 2, 1, 0, 0, 4'b1000);
    push(0, 161, 3, 0, 0, 1, 4'b0000);
    push(0, 181, 3, 0, 0, 0, 4'b0000);
    wait_n(124); call_req = 4'b1000;
    wait_n(125); call_req = 4'b0000;
    wait_n(185);

    // SCAN: heading up at floor 1 with {0,3} pending serves 3 first, then reverses to 0.
    do_reset();
    push(0, 5, 0, 1, 0, 0, 4'b1000);
    push(0, 17, 1, 1, 0, 0, 4'b1000);
    push(0, 29, 2, 1, 0, 0, 4'b1001);
    push(0, 41, 3, 0, 0, 1, 4'b0001);
    push(0, 61, 3, 0, 1, 0, 4'b0001);
    push(0, 73, 2, 0, 1, 0, 4'b0001);
    push(0, 85, 1, 0, 1, 0, 4'b0001);
    push(0, 97, 0, 0, 0, 1, 4'b0000);
    push(0, 117, 0, 0, 0, 0, 4'b0000);
    wait_n(4); call_req = 4'b1000;
    wait_n(5); call_req = 4'b0000;
    wait_n(17); call_req = 4'b0001;
    wait_n(18); call_req = 4'b0000;

    // Door extend at floor 2: call absorbed, door held 5 ticks from the call.
    push(0, 121, 0, 1, 0, 0, 4'b0100);
    push(0, 133, 1, 1, 0, 0, 4'b0100);
    push(0, 145, 2, 0, 0, 1, 4'b0000);
    push(1, 159, 2, 0, 0, 1, 4'b0000);
    push(0, 177, 2, 0, 0, 0, 4'b0000);
    wait_n(120); call_req = 4'b0100;
    wait_n(121); call_req = 4'b0000;
    wait_n(158); call_req = 4'b0100;
    wait_n(159); call_req = 4'b0000;
    wait_n(180);

    // Reset while travelling up between floors 1 and 2.
    do_reset();
    push(0, 5, 0, 1, 0, 0, 4'b1000);
    push(0, 17, 1, 1, 0, 0, 4'b1000);
    wait_n(4); call_req = 4'b1000;
    wait_n(5); call_req = 4'b0000;
    wait_n(21);
    do_reset();
    push(1, 30, 0, 0, 0, 0, 4'b0000);
    wait_n(31);
    done = 1'b1;
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 4, number of served floors (floor 0 = ground).
REQ-002 SHALL have parameter CLK_DIV, default 520833, system-clock cycles per scheduler tick.
REQ-003 SHALL have parameter TRAVEL_TICKS, default 3, ticks to move one floor.
REQ-004 SHALL have parameter DOOR_TICKS, default 5, ticks the door stays open.
REQ-005 SHALL have port clk  input  1  system clock; one clock, all logic on posedge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port call_req  input  NUM_FLOORS  per-floor call buttons, sampled every clk.
REQ-008 SHALL have port floor  output  $clog2(NUM_FLOORS)  current cab floor.
REQ-009 SHALL have port motor_up  output  1  cab moving up.
REQ-010 SHALL have port motor_down  output  1  cab moving down.
REQ-011 SHALL have port door_open  output  1  door open at floor.
REQ-012 SHALL have port pending  output  NUM_FLOORS  latched, not-yet-served calls.

Function
REQ-013 SHALL generate an internal 1-clk tick pulse every CLK_DIV clk cycles; all timers advance only on tick.
REQ-014 SHALL use states IDLE, MOVING, DOOR_OPEN; outputs are registered and decoded from state and direction.
REQ-015 SHALL set pending[i] on any clk where call_req[i]=1; bit stays set until served.
REQ-016 SHALL serve a floor by clearing its pending bit on DOOR_OPEN entry; clear wins over a same-cycle call_req for that floor.
REQ-017 IDLE: pending[floor]=1 -> DOOR_OPEN next clk; else pending above -> MOVING up; else pending below -> MOVING down; else stay IDLE.
REQ-018 Direction choice SHALL be SCAN: keep current direction while any pending floor lies ahead; else reverse if any lies behind; else IDLE.
REQ-019 MOVING: travel counter loads TRAVEL_TICKS on entry and decrements per tick; on the tick it would reach 0, floor steps +/-1 and counter reloads.
REQ-020 On floor step, if pending[new floor]=1 -> DOOR_OPEN next clk; else remain MOVING per REQ-018.
REQ-021 DOOR_OPEN: door counter loads DOOR_TICKS on entry, decrements per tick; on reaching 0 -> apply REQ-018 (IDLE if nothing pending).
REQ-022 A call for the current floor during DOOR_OPEN SHALL be absorbed (pending not set) and reload the door counter.
REQ-023 floor SHALL never leave 0..NUM_FLOORS-1; direction reverses at the end floors.
REQ-024 motor_up, motor_down, door_open SHALL be mutually exclusive; motor outputs high only in MOVING, door_open only in DOOR_OPEN.
REQ-025 Calls arriving during MOVING for floors being passed SHALL be served only if latched before the floor step tick.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, floor=0, direction=up, pending=0, all counters=0, motor_up=motor_down=door_open=0, at any time including mid-travel or door-open.
REQ-027 After rst release, the first tick SHALL occur CLK_DIV clk cycles later.

Structure
REQ-028 SHALL place state enum, direction encoding and default parameter constants in shared package elevator_pkg.
REQ-029 SHALL instantiate one sub-module tick_gen (CLK_DIV parameter, clk, rst, 1-clk tick output), replacing toggled divided clocks with an enable.

Verification (CLK_DIV=4, TRAVEL_TICKS=3, DOOR_TICKS=5, NUM_FLOORS=4)
REQ-030 Reset idle: no calls for 100 clk -> IDLE, floor=0, all outputs 0, pending=0.
REQ-031 Same-floor call: pulse call_req[0] in IDLE -> door_open=1 next clk, pending=0, door closes after 20 clk.
REQ-032 Travel: call_req[3] at floor 0 -> motor_up 36 clk, floor 1,2,3 each 12 clk apart, door_open at floor 3, pending[3] cleared.
REQ-033 SCAN order: at floor 1 moving up with pending {0,3} -> serve 3 then 0; floor 0 reached after door at 3 closes.
REQ-034 Door extend: call_req[2] during DOOR_OPEN at floor 2 -> pending[2] stays 0, door counter reloads to 5.
REQ-035 Reset mid-travel: rst=0 while motor_up=1 between floors 1 and 2 -> outputs 0, floor=0 immediately, pending=0.
